// File: rtl/led_pattern_seq.sv
// ============================================================================
// Module   : led_pattern_seq
// Purpose  : Steps the green LEDs through blink / walk-left / walk-right /
//            bounce patterns on 1 Hz ticks. A pushbutton cycles the mode and
//            a slide switch pauses stepping.
// Option   : define LEDSEQ_DEBOUNCE_EN to put a debouncer on the button.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module led_pattern_seq #(
  parameter int N_LED          = 10,
  parameter int TICKS_PER_STEP = 1,
  parameter int DEB_CYCLES     = 1_000_000
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             tick,
  input  logic             btn_n,
  input  logic             pause,
  output logic [N_LED-1:0] led,
  output logic [1:0]       mode
);

  localparam int                 c_CNT_W   = (TICKS_PER_STEP > 1) ? $clog2(TICKS_PER_STEP) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(TICKS_PER_STEP - 1);
  localparam logic [N_LED-1:0]   c_LED_ALL = '1;
  localparam logic [N_LED-1:0]   c_LED_LSB = N_LED'(1);
  localparam logic [N_LED-1:0]   c_LED_MSB = {1'b1, {(N_LED-1){1'b0}}};
  localparam logic               c_DIR_UP   = 1'b0;
  localparam logic               c_DIR_DOWN = 1'b1;

  typedef enum logic [1:0] {
    MODE_BLINK   = 2'b00,
    MODE_SHIFT_L = 2'b01,
    MODE_SHIFT_R = 2'b10,
    MODE_BOUNCE  = 2'b11
  } mode_t;

  // Parameter sanity: illegal values elaborate an empty marker block only.
  if ((N_LED < 2) || (TICKS_PER_STEP < 1) || (DEB_CYCLES < 1)) begin : g_param_check
  end

  logic r_btn_s1;
  logic r_btn_s2;
  logic r_btn_prev;
  logic r_pause_s1;
  logic r_pause_s2;
  logic w_btn_filt;
  logic w_press;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_btn_s1   <= 1'b1;
      r_btn_s2   <= 1'b1;
      r_btn_prev <= 1'b1;
      r_pause_s1 <= 1'b0;
      r_pause_s2 <= 1'b0;
    end else begin
      r_btn_s1   <= btn_n;
      r_btn_s2   <= r_btn_s1;
      r_btn_prev <= w_btn_filt;
      r_pause_s1 <= pause;
      r_pause_s2 <= r_pause_s1;
    end
  end

`ifdef LEDSEQ_DEBOUNCE_EN
  localparam int                 c_DEB_W   = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [c_DEB_W-1:0] c_DEB_MAX = c_DEB_W'(DEB_CYCLES - 1);

  logic               r_deb_stable;
  logic [c_DEB_W-1:0] r_deb_cnt;

  // The stable level only follows the synced button after DEB_CYCLES
  // consecutive disagreeing samples; any agreement restarts the window.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_deb_stable <= 1'b1;
      r_deb_cnt    <= '0;
    end else if (r_btn_s2 == r_deb_stable) begin
      r_deb_cnt    <= '0;
    end else if (r_deb_cnt == c_DEB_MAX) begin
      r_deb_stable <= r_btn_s2;
      r_deb_cnt    <= '0;
    end else begin
      r_deb_cnt    <= r_deb_cnt + 1'b1;
    end
  end

  assign w_btn_filt = r_deb_stable;
`else
  assign w_btn_filt = r_btn_s2;
`endif

  assign w_press = r_btn_prev & ~w_btn_filt;

  mode_t              r_mode;
  mode_t              w_mode_nxt;
  logic [N_LED-1:0]   r_led;
  logic [N_LED-1:0]   w_led_nxt;
  logic [c_CNT_W-1:0] r_cnt;
  logic [c_CNT_W-1:0] w_cnt_nxt;
  logic               r_dir;
  logic               w_dir_nxt;
  logic               w_tick_en;
  logic               w_step;

  assign w_tick_en = tick & ~r_pause_s2;
  assign w_step    = w_tick_en & (r_cnt == c_CNT_MAX);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_mode <= MODE_BLINK;
      r_led  <= c_LED_ALL;
      r_cnt  <= '0;
      r_dir  <= c_DIR_UP;
    end else begin
      r_mode <= w_mode_nxt;
      r_led  <= w_led_nxt;
      r_cnt  <= w_cnt_nxt;
      r_dir  <= w_dir_nxt;
    end
  end

  // A press outranks a coincident step: the pattern reloads and the step is dropped.
  always_comb begin
    w_mode_nxt = r_mode;
    w_led_nxt  = r_led;
    w_cnt_nxt  = r_cnt;
    w_dir_nxt  = r_dir;
    if (w_press) begin
      w_mode_nxt = mode_t'(r_mode + 2'd1);
      w_cnt_nxt  = '0;
      w_dir_nxt  = c_DIR_UP;
      case (w_mode_nxt)
        MODE_BLINK:   w_led_nxt = c_LED_ALL;
        MODE_SHIFT_L: w_led_nxt = c_LED_LSB;
        MODE_SHIFT_R: w_led_nxt = c_LED_MSB;
        MODE_BOUNCE:  w_led_nxt = c_LED_LSB;
        default:      w_led_nxt = c_LED_ALL;
      endcase
    end else if (w_tick_en) begin
      if (w_step) begin
        w_cnt_nxt = '0;
        case (r_mode)
          MODE_BLINK:   w_led_nxt = ~r_led;
          MODE_SHIFT_L: w_led_nxt = {r_led[N_LED-2:0], r_led[N_LED-1]};
          MODE_SHIFT_R: w_led_nxt = {r_led[0], r_led[N_LED-1:1]};
          MODE_BOUNCE: begin
            // Direction flips on the step that lands on an end bit.
            if (r_dir == c_DIR_UP) begin
              w_led_nxt = r_led << 1;
              if (w_led_nxt[N_LED-1]) w_dir_nxt = c_DIR_DOWN;
            end else begin
              w_led_nxt = r_led >> 1;
              if (w_led_nxt[0]) w_dir_nxt = c_DIR_UP;
            end
          end
          default:      w_led_nxt = r_led;
        endcase
      end else begin
        w_cnt_nxt = r_cnt + 1'b1;
      end
    end
  end

  assign led  = r_led;
  assign mode = r_mode;

endmodule

`default_nettype wire
